// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and slot-mask helper for the fetch controller
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam int BUNDLE_BYTES = 16;
   localparam int SLOTS        = 4;

   // Slots before the fetch PC's word offset are not part of the program stream.
   function automatic logic [SLOTS-1:0] slot_mask(input logic [1:0] offset);
      logic [SLOTS-1:0] m;
      case (offset)
         2'b00:   m = 4'b1111;
         2'b01:   m = 4'b1110;
         2'b10:   m = 4'b1100;
         default: m = 4'b1000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fetch_slot_mask.sv
// rtl/fetch_slot_mask.sv - splits a fetch PC into bundle-aligned address and slot-valid mask
module fetch_slot_mask
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   output logic [31:0] aligned_addr,
   output logic [3:0]  mask
);

   assign aligned_addr = pc & 32'hFFFF_FFF0;
   assign mask         = slot_mask(pc[3:2]);

endmodule

// File: rtl/fetch_bundle_ctrl.sv
// rtl/fetch_bundle_ctrl.sv - single-outstanding bundle fetch sequencer with redirect and stale-response drain
module fetch_bundle_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [127:0]     imem_rdata,
   output logic             bundle_valid,
   output logic [31:0]      bundle_pc,
   output logic [127:0]     bundle_data,
   output logic [3:0]       slot_valid,
   input  logic             decode_ready,
   output logic [CNT_W-1:0] bundle_count
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  aligned_addr;
   logic [3:0]   mask;
   logic [31:0]  redirect_word;

   fetch_slot_mask u_slot_mask (
      .pc           (pc),
      .aligned_addr (aligned_addr),
      .mask         (mask)
   );

   assign redirect_word = redirect_pc & 32'hFFFF_FFFC;
   assign imem_addr     = aligned_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= REQ;
         pc           <= RESET_PC;
         imem_req     <= 1'b1;
         bundle_valid <= 1'b0;
         bundle_pc    <= 32'h0;
         bundle_data  <= 128'h0;
         slot_valid   <= 4'b0000;
         bundle_count <= '0;
      end else begin
         case (state)
            REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_word;
                  // An accepted old request still owes a response that must be dropped.
                  if (imem_ready) begin
                     state    <= DRAIN;
                     imem_req <= 1'b0;
                  end
               end else if (imem_ready) begin
                  state    <= WAIT;
                  imem_req <= 1'b0;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc <= redirect_word;
                  if (imem_rvalid) begin
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (imem_rvalid) begin
                  bundle_data  <= imem_rdata;
                  bundle_pc    <= aligned_addr;
                  slot_valid   <= mask;
                  bundle_valid <= 1'b1;
                  pc           <= aligned_addr + 32'(BUNDLE_BYTES);
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc           <= redirect_word;
                  bundle_valid <= 1'b0;
                  state        <= REQ;
                  imem_req     <= 1'b1;
               end else if (decode_ready) begin
                  bundle_count <= bundle_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  bundle_valid <= 1'b0;
                  state        <= REQ;
                  imem_req     <= 1'b1;
               end
            end
            DRAIN: begin
               if (redirect_valid) begin
                  pc <= redirect_word;
               end
               if (imem_rvalid) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            default: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
         endcase
      end
   end

   rvalid_only_when_expected: assert property (
      @(posedge clk) disable iff (reset)
      imem_rvalid |-> (state == WAIT || state == DRAIN)
   );

endmodule

// File: tb/tb_fetch_bundle_ctrl.sv
// tb/tb_fetch_bundle_ctrl.sv - directed self-checking bench for fetch_bundle_ctrl
module tb_fetch_bundle_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_ready;
   logic         imem_rvalid;
   logic [127:0] imem_rdata;
   logic         bundle_valid;
   logic [31:0]  bundle_pc;
   logic [127:0] bundle_data;
   logic [3:0]   slot_valid;
   logic         decode_ready;
   logic [31:0]  bundle_count;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [127:0] D1 = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
   localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] D5 = 128'h01020304_05060708_090A0B0C_0D0E0F10;

   fetch_bundle_ctrl #(
      .RESET_PC (32'hBFC0_0000),
      .CNT_W    (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .bundle_valid   (bundle_valid),
      .bundle_pc      (bundle_pc),
      .bundle_data    (bundle_data),
      .slot_valid     (slot_valid),
      .decode_ready   (decode_ready),
      .bundle_count   (bundle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // From REQ: accept immediately, respond the next cycle; leaves the DUT in HOLD.
   task automatic fetch_fast(input logic [127:0] d);
      imem_ready = 1'b1;
      cyc();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = d;
      cyc();
      imem_rvalid = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] p);
      redirect_valid = 1'b1;
      redirect_pc    = p;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_ready     = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 128'h0;
      decode_ready   = 1'b0;
      cyc();
      cyc();
      chk("rst_bundle_valid", bundle_valid, 1'b0);
      chk("rst_bundle_pc", bundle_pc, 32'h0);
      chk("rst_bundle_data", bundle_data, 128'h0);
      chk("rst_slot_valid", slot_valid, 4'b0000);
      chk("rst_count", bundle_count, 32'h0);

      // Basic fetch with response two cycles after acceptance.
      reset = 1'b0;
      cyc();
      chk("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'hBFC0_0000);
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0;
      chk("t1_wait_noreq", imem_req, 1'b0);
      cyc();
      chk("t1_wait_novalid", bundle_valid, 1'b0);
      imem_rvalid = 1'b1;
      imem_rdata  = D1;
      cyc();
      imem_rvalid = 1'b0;
      chk("t1_bvalid", bundle_valid, 1'b1);
      chk("t1_bpc", bundle_pc, 32'hBFC0_0000);
      chk("t1_bdata", bundle_data, D1);
      chk("t1_slots", slot_valid, 4'b1111);
      decode_ready = 1'b1;
      cyc();
      decode_ready = 1'b0;
      chk("t1_bvalid_clr", bundle_valid, 1'b0);
      chk("t1_count", bundle_count, 32'd1);
      chk("t1_next_req", imem_req, 1'b1);
      chk("t1_next_addr", imem_addr, 32'hBFC0_0010);

      // Redirect in HOLD to a mid-bundle PC.
      fetch_fast(D2);
      chk("t2_hold_pc", bundle_pc, 32'hBFC0_0010);
      redirect_to(32'h0040_0008);
      cyc();
      redirect_valid = 1'b0;
      chk("t2_bvalid_clr", bundle_valid, 1'b0);
      chk("t2_count_same", bundle_count, 32'd1);
      chk("t2_addr", imem_addr, 32'h0040_0000);
      chk("t2_req", imem_req, 1'b1);
      fetch_fast(D2);
      chk("t2_slots", slot_valid, 4'b1100);
      chk("t2_bpc", bundle_pc, 32'h0040_0000);
      chk("t2_bdata", bundle_data, D2);
      decode_ready = 1'b1;
      cyc();
      decode_ready = 1'b0;
      chk("t2_count", bundle_count, 32'd2);
      chk("t2_next_addr", imem_addr, 32'h0040_0010);

      // Redirect while requesting without imem_ready.
      redirect_to(32'h0040_000C);
      cyc();
      redirect_valid = 1'b0;
      chk("t3_addr", imem_addr, 32'h0040_0000);
      fetch_fast(D3);
      chk("t3_slots", slot_valid, 4'b1000);
      decode_ready = 1'b1;
      cyc();
      decode_ready = 1'b0;
      redirect_to(32'h0040_0006);
      cyc();
      redirect_valid = 1'b0;
      chk("t3b_addr", imem_addr, 32'h0040_0000);
      fetch_fast(D3);
      chk("t3b_slots", slot_valid, 4'b1110);
      decode_ready = 1'b1;
      cyc();
      decode_ready = 1'b0;
      chk("t3b_count", bundle_count, 32'd4);
      chk("t3b_next_addr", imem_addr, 32'h0040_0010);

      // Redirect in WAIT, stale response arrives three cycles later.
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0;
      redirect_to(32'h0050_0000);
      cyc();
      redirect_valid = 1'b0;
      chk("t4_drain_noreq", imem_req, 1'b0);
      cyc();
      chk("t4_drain_noreq2", imem_req, 1'b0);
      imem_rvalid = 1'b1;
      imem_rdata  = D1;
      cyc();
      imem_rvalid = 1'b0;
      chk("t4_no_bvalid", bundle_valid, 1'b0);
      chk("t4_req", imem_req, 1'b1);
      chk("t4_addr", imem_addr, 32'h0050_0000);
      chk("t4_count", bundle_count, 32'd4);

      // Redirect coincident with the response in WAIT.
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0;
      redirect_to(32'h0060_0000);
      imem_rvalid = 1'b1;
      imem_rdata  = D2;
      cyc();
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      chk("t5_no_bvalid", bundle_valid, 1'b0);
      chk("t5_req", imem_req, 1'b1);
      chk("t5_addr", imem_addr, 32'h0060_0000);

      // Back-pressure in HOLD, then redirect with decode_ready high.
      fetch_fast(D5);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t6_hold_bvalid", bundle_valid, 1'b1);
         chk("t6_hold_bdata", bundle_data, D5);
         chk("t6_hold_bpc", bundle_pc, 32'h0060_0000);
         chk("t6_hold_slots", slot_valid, 4'b1111);
         chk("t6_hold_noreq", imem_req, 1'b0);
      end
      redirect_to(32'hFFFF_FFF0);
      decode_ready = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      decode_ready   = 1'b0;
      chk("t6_bvalid_clr", bundle_valid, 1'b0);
      chk("t6_count_same", bundle_count, 32'd4);
      chk("t6_addr", imem_addr, 32'hFFFF_FFF0);

      // Address wrap at the top of the address space.
      fetch_fast(D1);
      chk("t7_bpc", bundle_pc, 32'hFFFF_FFF0);
      decode_ready = 1'b1;
      cyc();
      decode_ready = 1'b0;
      chk("t7_count", bundle_count, 32'd5);
      chk("t7_wrap_addr", imem_addr, 32'h0000_0000);

      // Redirect in REQ while the old request is accepted.
      imem_ready = 1'b1;
      redirect_to(32'h0070_0000);
      cyc();
      imem_ready     = 1'b0;
      redirect_valid = 1'b0;
      chk("t8_drain_noreq", imem_req, 1'b0);
      imem_rvalid = 1'b1;
      cyc();
      imem_rvalid = 1'b0;
      chk("t8_req", imem_req, 1'b1);
      chk("t8_addr", imem_addr, 32'h0070_0000);
      chk("t8_no_bvalid", bundle_valid, 1'b0);

      // Asynchronous reset while waiting for a response.
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("t9_rst_count", bundle_count, 32'h0);
      chk("t9_rst_bvalid", bundle_valid, 1'b0);
      chk("t9_rst_bpc", bundle_pc, 32'h0);
      chk("t9_rst_bdata", bundle_data, 128'h0);
      chk("t9_rst_slots", slot_valid, 4'b0000);
      chk("t9_rst_req", imem_req, 1'b1);
      cyc();
      reset = 1'b0;
      cyc();
      chk("t9_req", imem_req, 1'b1);
      chk("t9_addr", imem_addr, 32'hBFC0_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
